// File: rtl/regs_mp.sv
// Parametrised multi-port register file with a hardware clear sequencer and registered reads.
// Optional macro REGS_BYPASS_EN: same-cycle write data is forwarded to matching read ports.
module regs_mp #(
    parameter int n  = 8,
    parameter int AW = 5,
    parameter int NR = 2
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             clr,
    input  logic             w,
    input  logic [AW-1:0]    Waddr,
    input  logic [n-1:0]     Wdata,
    input  logic             w2,
    input  logic [AW-1:0]    Waddr2,
    input  logic [n-1:0]     Wdata2,
    input  logic [NR*AW-1:0] Raddr,
    output logic [NR*n-1:0]  Rdata,
    output logic             ready
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          cnt_q, cnt_d;
    logic                   clr_we, run_we;
    logic [NR-1:0][n-1:0]   rdata_q, rdata_d;
    logic [n-1:0]           mem_q [2**AW];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // run_we is also the read-capture enable: a clr edge discards writes and captures zeros.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        run_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == {AW{1'b1}}) state_d = RUN;
            end
            RUN: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    run_we = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Port 2 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[cnt_q] <= '0;
        end else if (run_we) begin
            if (w && Waddr != '0)   mem_q[Waddr]  <= Wdata;
            if (w2 && Waddr2 != '0) mem_q[Waddr2] <= Wdata2;
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic [n-1:0]  rd;
        assign ra = Raddr[k*AW +: AW];
        always_comb begin
            rd = mem_q[ra];
`ifdef REGS_BYPASS_EN
            if (w2 && Waddr2 == ra)     rd = Wdata2;
            else if (w && Waddr == ra)  rd = Wdata;
`endif
            if (ra == '0 || !run_we) rd = '0;
        end
        assign rdata_d[k] = rd;
    end

    assign Rdata = rdata_q;
    assign ready = (state_q == RUN);

endmodule

// File: tb/tb_regs_mp.sv
// Randomised self-checking bench for regs_mp against an array-based reference model.
module tb_regs_mp;
    localparam int N = 8, AW = 5, NR = 2, DEPTH = 32;

    logic             clk = 1'b0, nReset = 1'b0, clr = 1'b0;
    logic             w = 1'b0, w2 = 1'b0;
    logic [AW-1:0]    Waddr = '0, Waddr2 = '0;
    logic [N-1:0]     Wdata = '0, Wdata2 = '0;
    logic [AW-1:0]    ra [NR];
    logic [NR*AW-1:0] Raddr;
    logic [NR*N-1:0]  Rdata;
    logic             ready;

    int checks = 0, errors = 0;
    logic [N-1:0] model [DEPTH];
    int left;  // clear cycles still to run; 0 means the file is usable

    always #5 clk = ~clk;
    always_comb for (int k = 0; k < NR; k++) Raddr[k*AW +: AW] = ra[k];

    regs_mp #(.n(N), .AW(AW), .NR(NR)) dut (
        .clk(clk), .nReset(nReset), .clr(clr),
        .w(w), .Waddr(Waddr), .Wdata(Wdata),
        .w2(w2), .Waddr2(Waddr2), .Wdata2(Wdata2),
        .Raddr(Raddr), .Rdata(Rdata), .ready(ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wipe();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        left = DEPTH;
    endtask

    task automatic idle();
        clr = 0; w = 0; w2 = 0; Waddr = '0; Waddr2 = '0; Wdata = '0; Wdata2 = '0;
        for (int k = 0; k < NR; k++) ra[k] = '0;
    endtask

    // One clock edge with the currently driven inputs; checks outputs just after it.
    task automatic step(input string tag);
        logic [N-1:0] exp [NR];
        for (int k = 0; k < NR; k++) begin
            exp[k] = '0;
            if (left == 0 && !clr && ra[k] != 0) begin
                exp[k] = model[ra[k]];
`ifdef REGS_BYPASS_EN
                if (w2 && Waddr2 == ra[k])     exp[k] = Wdata2;
                else if (w && Waddr == ra[k])  exp[k] = Wdata;
`endif
            end
        end
        if (left > 0) left--;
        else if (clr) wipe();
        else begin
            if (w && Waddr != 0)   model[Waddr]  = Wdata;
            if (w2 && Waddr2 != 0) model[Waddr2] = Wdata2;
        end
        @(posedge clk); #1;
        chk({tag, ".ready"}, 32'(ready), 32'(left == 0));
        for (int k = 0; k < NR; k++) chk({tag, ".rd"}, 32'(Rdata[k*N +: N]), 32'(exp[k]));
    endtask

    task automatic read2(input int a0, input int a1, input string tag);
        idle(); ra[0] = AW'(a0); ra[1] = AW'(a1); step(tag);
    endtask

    initial begin
        idle();
        wipe();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", 32'(ready), 0);
        chk("rst.rdata", 32'(Rdata), 0);
        @(negedge clk); nReset = 1;

        // clear sequence; a write during it must be dropped
        for (int i = 0; i < DEPTH; i++) begin
            idle(); w = 1; Waddr = 4; Wdata = 7;
            step("clear");
        end
        for (int a = 1; a < DEPTH; a++) read2(a, DEPTH - a, "zero");

        idle(); w = 1; Waddr = 1; Wdata = 11; w2 = 1; Waddr2 = 2; Wdata2 = 12; step("wr12");
        read2(1, 2, "rd12");
        chk("rd12.p0", 32'(Rdata[0 +: N]), 11);
        chk("rd12.p1", 32'(Rdata[N +: N]), 12);

        idle(); w = 1; w2 = 1; Waddr = 3; Waddr2 = 3; Wdata = 5; Wdata2 = 8'hFF; step("coll");
        read2(3, 3, "rdcoll");
        chk("coll.val", 32'(Rdata[0 +: N]), 32'hFF);

        idle(); w = 1; Waddr = 0; Wdata = 8'hAA; step("wr0");
        read2(0, 0, "rd0");

        idle(); w = 1; Waddr = 5; Wdata = 20; step("wr5");
        idle(); w = 1; Waddr = 5; Wdata = 33; ra[0] = 5; ra[1] = 5; step("rdw");
`ifdef REGS_BYPASS_EN
        chk("rdw.val", 32'(Rdata[0 +: N]), 33);
`else
        chk("rdw.val", 32'(Rdata[0 +: N]), 20);
`endif
        read2(5, 1, "rd5");

        idle(); clr = 1; w = 1; Waddr = 6; Wdata = 9; step("clr");
        for (int i = 0; i < DEPTH; i++) begin idle(); step("reclear"); end
        read2(1, 6, "postclr");

        // reset in the middle of a clear
        idle(); clr = 1; step("clr2");
        for (int i = 0; i < 10; i++) begin idle(); step("midclear"); end
        nReset = 0; #1;
        chk("midrst.ready", 32'(ready), 0);
        chk("midrst.rdata", 32'(Rdata), 0);
        wipe();
        @(negedge clk); nReset = 1;
        for (int i = 0; i < DEPTH; i++) begin idle(); step("clear2"); end

        for (int i = 0; i < 600; i++) begin
            clr    = ($urandom_range(0, 63) == 0);
            w      = $urandom_range(0, 1);
            w2     = $urandom_range(0, 1);
            Waddr  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            Waddr2 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            Wdata  = N'($urandom);
            Wdata2 = N'($urandom);
            for (int k = 0; k < NR; k++)
                ra[k] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regs_mp.md
Name: regs_mp

Overview:
- Parametrised multi-port register file for the pMIPS datapath.
- Successor to the fixed 32 x n, 2-read/2-write file. Width, depth and read-port count are configurable.
- Adds a hardware clear sequencer after reset or on request, a ready flag, defined write-collision priority, registered reads and optional read-during-write bypass.
- Register 0 is hardwired to zero.

Parameters:
- n, 8, data width in bits.
- AW, 5, address width; depth = 2**AW registers.
- NR, 2, number of read ports (1..4).

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- nReset  in  1  asynchronous active-low reset.
- clr  in  1  synchronous request to re-run the clear sequence.
- w  in  1  write enable, port 1.
- Waddr  in  AW  write address, port 1.
- Wdata  in  n  write data, port 1.
- w2  in  1  write enable, port 2.
- Waddr2  in  AW  write address, port 2.
- Wdata2  in  n  write data, port 2.
- Raddr  in  NR*AW  read addresses, flattened; port k uses bits [k*AW +: AW].
- Rdata  out  NR*n  registered read data, flattened; port k uses bits [k*n +: n].
- ready  out  1  high when the file accepts writes and reads are valid.

Behaviour:
- Reset: clock is clk; reset is nReset, asynchronous, active low.
- While nReset is low: Rdata = 0, ready = 0, state = CLEAR, clear counter = 0. Storage is not reset directly.
- State machine, two states: CLEAR and RUN.
- CLEAR:
  - Each cycle, write 0 to the register at the counter address, then increment the counter.
  - When the counter reaches 2**AW-1, clear that register and go to RUN on the same edge.
  - A full clear takes 2**AW cycles after nReset rises.
  - w and w2 are ignored. ready = 0. Rdata = 0.
- RUN:
  - ready = 1.
  - clr = 1 on a clock edge: enter CLEAR and reset the counter to 0. Any write in that same cycle is discarded.
- Writes (RUN only): on the clock edge, mem[Waddr] <= Wdata if w; mem[Waddr2] <= Wdata2 if w2.
- Collision: if w and w2 are both high and Waddr == Waddr2, port 2 (Wdata2) wins.
- Register 0: writes to address 0 are ignored. Reads of address 0 always return 0.
- Reads:
  - Rdata for port k is registered, with 1-cycle latency: the value at the edge after Raddr[k] is presented.
  - In CLEAR, Rdata is forced to 0.
  - All NR ports read independently. Duplicate addresses are allowed.
- Read-during-write (same address, same cycle): behaviour is set by the optional feature below.
- Reset mid-clear or mid-run: the sequence restarts from address 0 when nReset rises.
- clr held high in RUN: the file re-enters CLEAR on every edge where state is RUN. There is no effect while already in CLEAR.

Optional Feature:
- Macro: REGS_BYPASS_EN.
- Defined: a read port whose address matches an enabled write in the same cycle captures the new data. Port 2 data is used if both writes match. Address 0 still reads 0.
- Undefined: that read port captures the old contents.

Test Plan:
- Reset release, n=8, AW=5: ready stays 0 for exactly 32 cycles after nReset rises, then goes to 1. After that, reads of addresses 1..31 all give 0.
- RUN, w=1 Waddr=1 Wdata=11, w2=1 Waddr2=2 Wdata2=12, then read Raddr0=1 Raddr1=2: Rdata0 = 11 and Rdata1 = 12, one cycle after the address is applied.
- Collision, w=w2=1, Waddr=Waddr2=3, Wdata=5, Wdata2=8'hFF: a later read of address 3 gives 8'hFF.
- Write 8'hAA to address 0, then read Raddr=0: result is 0. During CLEAR, Wdata=7 to address 4 is dropped; address 4 still reads 0 after ready rises.
- After writing 11 to address 1, pulse clr for one cycle: ready = 0 for 32 cycles, then address 1 reads 0. Separately, pull nReset low mid-clear: Rdata = 0 immediately and the clear restarts.
- Write 33 to address 5 while reading address 5 in the same cycle: captured Rdata = 33 with REGS_BYPASS_EN defined; the previous value without it.
